// File: rtl/mod_reduce_pkg.sv
// Shared types and sizing helpers for the sequential residue unit and the RNS lanes.
// Latency: n/a (package).
// Backpressure: n/a (package).
package mod_reduce_pkg;

    // Default operating point shared with the residue-domain lanes.
    localparam int MODRED_MOD     = 2011;
    localparam int MODRED_IN_W    = 500;
    localparam int MODRED_CHUNK_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of CHUNK_W-bit chunks needed to cover an IN_W-bit operand.
    function automatic int nch(input int in_w, input int chunk_w);
        return (in_w + chunk_w - 1) / chunk_w;
    endfunction

    // Residue width. MOD is odd and >= 3, so it is never a power of two,
    // which means $clog2(MOD) bits hold every value 0..MOD-1.
    function automatic int out_w(input int mod);
        return $clog2(mod);
    endfunction

endpackage

// File: rtl/mod_fold_step.sv
// One Horner fold: acc' = (acc * 2^CHUNK_W + chunk) mod MOD, with acc < MOD on entry.
// Latency: combinational (0 cycles).
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   acc_i   [OUT_W-1:0]    running residue, must be < MOD
//   chunk_i [CHUNK_W-1:0]  next operand chunk (MSB-first order)
//   acc_o   [OUT_W-1:0]    folded residue, always < MOD
module mod_fold_step
    import mod_reduce_pkg::*;
#(
    parameter int  MOD     = MODRED_MOD,
    parameter int  CHUNK_W = MODRED_CHUNK_W,
    localparam int OUT_W   = out_w(MOD)
) (
    input  logic [OUT_W-1:0]   acc_i,
    input  logic [CHUNK_W-1:0] chunk_i,
    output logic [OUT_W-1:0]   acc_o
);

    localparam int             W     = OUT_W + CHUNK_W;
    localparam logic [W-1:0]   MOD_W = W'(MOD);

    logic [W-1:0] t;
    logic         unused_hi;

    // Since acc_i < MOD, {acc_i, chunk_i} < MOD << CHUNK_W. Each restoring
    // stage k leaves t < MOD << k, so after stage 0 the value is < MOD.
    always_comb begin
        t = {acc_i, chunk_i};
        for (int k = CHUNK_W - 1; k >= 0; k--) begin
            if (t >= (MOD_W << k)) begin
                t = t - (MOD_W << k);
            end
        end
    end

    assign acc_o     = t[OUT_W-1:0];
    // Upper bits are provably zero after the last stage.
    assign unused_hi = ^t[W-1:OUT_W];

endmodule

// File: rtl/mod_reduce_seq.sv
// Sequential residue unit: out_data = in_data mod MOD, folding CHUNK_W-bit chunks MSB-first.
// Latency: NCH cycles accept->out_valid (ceil(NCH/2) when MODRED_DUAL_FOLD_EN is defined).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; flush aborts anywhere.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   flush                  sync abort to IDLE, discards operand and pending result
//   in_valid/in_ready      operand handshake, in_data [IN_W-1:0] unsigned
//   out_valid/out_ready    result handshake, out_data [OUT_W-1:0] < MOD
//   busy                   high in RUN or DONE
// Build option: define MODRED_DUAL_FOLD_EN to chain two folds per cycle.
module mod_reduce_seq
    import mod_reduce_pkg::*;
#(
    parameter int  MOD     = MODRED_MOD,
    parameter int  IN_W    = MODRED_IN_W,
    parameter int  CHUNK_W = MODRED_CHUNK_W,
    localparam int OUT_W   = out_w(MOD)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             busy
);

    localparam int NCH = nch(IN_W, CHUNK_W);
`ifdef MODRED_DUAL_FOLD_EN
    localparam int FOLDS = 2;
`else
    localparam int FOLDS = 1;
`endif
    localparam int STEPS = (NCH + FOLDS - 1) / FOLDS;
    // With two folds per cycle and odd NCH the operand is padded by one extra
    // zero chunk at the MSB; folding a leading zero leaves acc at 0.
    localparam int SR_W  = STEPS * FOLDS * CHUNK_W;
    localparam int SHIFT = FOLDS * CHUNK_W;
    localparam int CNT_W = $clog2(STEPS + 1);

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;

    logic [OUT_W-1:0]   acc_f1;
    logic [OUT_W-1:0]   acc_nxt;
    logic               last_step;

    mod_fold_step #(
        .MOD     (MOD),
        .CHUNK_W (CHUNK_W)
    ) u_fold0 (
        .acc_i   (acc_q),
        .chunk_i (sr_q[SR_W-1 -: CHUNK_W]),
        .acc_o   (acc_f1)
    );

`ifdef MODRED_DUAL_FOLD_EN
    mod_fold_step #(
        .MOD     (MOD),
        .CHUNK_W (CHUNK_W)
    ) u_fold1 (
        .acc_i   (acc_f1),
        .chunk_i (sr_q[SR_W-CHUNK_W-1 -: CHUNK_W]),
        .acc_o   (acc_nxt)
    );
`else
    assign acc_nxt = acc_f1;
`endif

    assign last_step = (cnt_q == CNT_W'(STEPS - 1));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (flush) begin
            // Abort overrides accept, fold and handshake on the same edge.
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_d = RUN;
                        sr_d    = SR_W'(in_data);
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end
                RUN: begin
                    acc_d = acc_nxt;
                    sr_d  = sr_q << SHIFT;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_step) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = acc_nxt;
                    end
                end
                DONE: begin
                    // Returning to IDLE here means the next accept is at least
                    // one cycle after the result handshake.
                    if (out_ready) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            sr_q        <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_mod_reduce_seq.sv
// Directed bench for mod_reduce_seq at default parameters plus a small-parameter
// instance driven with random back-to-back operands against a big-integer model.
// Expected values are hand-computed constants or X % MOD evaluated by the bench.
module tb_mod_reduce_seq;
    import mod_reduce_pkg::*;

    localparam int MOD     = 2011;
    localparam int IN_W    = 500;
    localparam int CHUNK_W = 6;
    localparam int OUT_W   = 11;
`ifdef MODRED_DUAL_FOLD_EN
    localparam int LAT     = 42;
`else
    localparam int LAT     = 84;
`endif

    localparam int S_MOD     = 97;
    localparam int S_IN_W    = 37;
    localparam int S_CHUNK_W = 5;
    localparam int S_OUT_W   = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [IN_W-1:0]     in_data;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_W-1:0]    out_data;
    logic                busy;

    logic                s_flush;
    logic                s_in_valid;
    logic                s_in_ready;
    logic [S_IN_W-1:0]   s_in_data;
    logic                s_out_valid;
    logic                s_out_ready;
    logic [S_OUT_W-1:0]  s_out_data;
    logic                s_busy;

    mod_reduce_seq #(
        .MOD     (MOD),
        .IN_W    (IN_W),
        .CHUNK_W (CHUNK_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    mod_reduce_seq #(
        .MOD     (S_MOD),
        .IN_W    (S_IN_W),
        .CHUNK_W (S_CHUNK_W)
    ) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (s_flush),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_data),
        .busy      (s_busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents x for one edge, then counts edges until out_valid appears.
    task automatic run_op(input logic [IN_W-1:0] x, input logic rdy, output int lat);
        check("in_ready before accept", {63'd0, in_ready}, 64'd1);
        in_data   = x;
        in_valid  = 1'b1;
        out_ready = rdy;
        step();
        in_valid  = 1'b0;
        check("busy after accept", {63'd0, busy}, 64'd1);
        check("in_ready low after accept", {63'd0, in_ready}, 64'd0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 400) begin
            step();
            lat++;
        end
    endtask

    // Runs one operand with out_ready high and checks result and latency.
    task automatic vec(input string tag, input logic [IN_W-1:0] x, input logic [63:0] exp);
        int lat;
        run_op(x, 1'b1, lat);
        check($sformatf("%s result", tag), {53'd0, out_data}, exp);
        check($sformatf("%s latency", tag), 64'(lat), 64'(LAT));
        step();
        check($sformatf("%s idle after handshake", tag), {63'd0, out_valid}, 64'd0);
    endtask

    logic [IN_W-1:0]   big;
    logic [IN_W-1:0]   bmod;
    logic [S_IN_W-1:0] sx;
    logic [S_IN_W-1:0] q_exp[$];
    int                lat;
    int                seen;
    int                sent;
    int                got;
    logic [63:0]       exp_s;

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        s_flush     = 1'b0;
        s_in_valid  = 1'b0;
        s_in_data   = '0;
        s_out_ready = 1'b0;
        step();
        step();

        // Reset state
        check("reset out_valid", {63'd0, out_valid}, 64'd0);
        check("reset out_data", {53'd0, out_data}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset in_ready", {63'd0, in_ready}, 64'd1);
        rst_n = 1'b1;
        step();

        // Directed values
        vec("x0", 500'd0, 64'd0);
        vec("x2010", 500'd2010, 64'd2010);
        vec("x2011", 500'd2011, 64'd0);
        vec("x64", 500'd64, 64'd64);
        vec("x4046132", 500'd4046132, 64'd0);
        vec("x4046133", 500'd4046133, 64'd1);
        big  = '1;
        bmod = big % 500'(MOD);
        vec("xall1", big, 64'(bmod));
        big  = {1'b1, 499'd0} | 500'd12345;
        bmod = big % 500'(MOD);
        vec("xmsb", big, 64'(bmod));

        // Consumer stall in DONE; in_valid during DONE must be ignored
        run_op(500'd12345, 1'b0, lat);
        check("stall latency", 64'(lat), 64'(LAT));
        in_data  = 500'd7;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("stall out_valid", {63'd0, out_valid}, 64'd1);
            check("stall out_data", {53'd0, out_data}, 64'd279);
            check("stall in_ready", {63'd0, in_ready}, 64'd0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("stall released out_valid", {63'd0, out_valid}, 64'd0);
        check("stall released in_ready", {63'd0, in_ready}, 64'd1);
        check("out_data kept after handshake", {53'd0, out_data}, 64'd279);

        // Reset at cycle 40 of RUN
        run_op(500'd5000, 1'b1, lat);
        step();
        in_data  = 500'd5000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 39; i++) step();
        rst_n = 1'b0;
        #1;
        check("mid-run reset out_valid", {63'd0, out_valid}, 64'd0);
        check("mid-run reset busy", {63'd0, busy}, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        check("after reset in_ready", {63'd0, in_ready}, 64'd1);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid === 1'b1) seen++;
            step();
        end
        check("no result after reset", 64'(seen), 64'd0);
        vec("x2012", 500'd2012, 64'd1);

        // Flush in RUN
        in_data  = 500'd777;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush run busy", {63'd0, busy}, 64'd0);
        check("flush run in_ready", {63'd0, in_ready}, 64'd1);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid === 1'b1) seen++;
            step();
        end
        check("flush run no result", 64'(seen), 64'd0);

        // Flush in DONE
        run_op(500'd100, 1'b0, lat);
        check("pre-flush done out_valid", {63'd0, out_valid}, 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush done out_valid", {63'd0, out_valid}, 64'd0);
        check("flush done busy", {63'd0, busy}, 64'd0);

        // Flush coincident with in_valid in IDLE
        flush    = 1'b1;
        in_data  = 500'd55;
        in_valid = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush+valid no accept busy", {63'd0, busy}, 64'd0);
        check("flush+valid in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        vec("x after flush", 500'd4022, 64'd0);

        // Small build: random back-to-back operands with random out_ready
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40000 && got < 1000; cyc++) begin
            sx          = S_IN_W'({$urandom, $urandom});
            if ((cyc % 7) == 3) sx = '1;
            s_in_data   = sx;
            s_in_valid  = (sent < 1000);
            s_out_ready = 1'($urandom_range(0, 1));
            #0;
            if (s_in_valid && s_in_ready) begin
                q_exp.push_back(sx % S_IN_W'(S_MOD));
                sent++;
            end
            if (s_out_valid && s_out_ready) begin
                exp_s = (q_exp.size() > 0) ? 64'(q_exp.pop_front()) : 64'hFFFF;
                check("small random result", {57'd0, s_out_data}, exp_s);
                got++;
            end
            step();
        end
        s_in_valid = 1'b0;
        check("small random count", 64'(got), 64'd1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
